// File: rtl/xaddrgen2d.sv
// xaddrgen2d -- two-level (nested-loop) address generator for Versat memory units.
//
// Inner loop: each window is `period` cycles long and mem_en is asserted on its first
// `duty` cycles. After `iter_in` windows the outer loop steps once; `iter_out` outer
// steps make up one run. An optional `delay` of idle cycles precedes the first window.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   init            IDLE only: load start into the address register
//   run             start from IDLE, or seamless restart on the final RUN cycle
//   pause           freeze counters/address/state; masks mem_en
//   abort           return to IDLE next cycle, address held (beats run/pause/init)
//   iter_in/out     inner / outer iteration counts (0 treated as 1)
//   period/duty     window length and enabled cycles per window
//   delay           idle cycles between run and first window
//   start           first address
//   incr            signed step per enabled cycle
//   shift_in/out    signed step at end of each window / end of each inner loop
//   addr            current address (registered)
//   mem_en          address valid
//   done            high while IDLE
module xaddrgen2d #(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10,
    parameter int ITER_W   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                run,
    input  logic                pause,
    input  logic                abort,
    input  logic [ITER_W-1:0]   iter_in,
    input  logic [ITER_W-1:0]   iter_out,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] duty,
    input  logic [PERIOD_W-1:0] delay,
    input  logic [ADDR_W-1:0]   start,
    input  logic [ADDR_W-1:0]   incr,
    input  logic [ADDR_W-1:0]   shift_in,
    input  logic [ADDR_W-1:0]   shift_out,
    output logic [ADDR_W-1:0]   addr,
    output logic                mem_en,
    output logic                done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]          state;
    logic [PERIOD_W-1:0] per_cnt, dly_cnt;
    logic [ITER_W-1:0]   ic, oc;

    // Shadowed (already clamped) configuration, captured on the accepted run edge.
    logic [PERIOD_W-1:0] per_s, duty_s, delay_s;
    logic [ITER_W-1:0]   itin_s, itout_s;
    logic [ADDR_W-1:0]   incr_s, shin_s, shout_s;

    // Clamped view of the live inputs, only used when loading the shadows.
    logic [PERIOD_W-1:0] per_c, duty_c;
    logic [ITER_W-1:0]   itin_c, itout_c;

    logic                win_end, in_last, out_last, final_cyc, en_win, start_run;
    logic [ADDR_W-1:0]   step;

    always_comb begin
        per_c   = (period == '0) ? PERIOD_W'(1) : period;
        duty_c  = (duty > per_c) ? per_c : duty;
        itin_c  = (iter_in == '0) ? ITER_W'(1) : iter_in;
        itout_c = (iter_out == '0) ? ITER_W'(1) : iter_out;
    end

    assign win_end   = (per_cnt == per_s - PERIOD_W'(1));
    assign in_last   = (ic == itin_s - ITER_W'(1));
    assign out_last  = (oc == itout_s - ITER_W'(1));
    assign final_cyc = (state == S_RUN) && win_end && in_last && out_last;
    assign en_win    = (state == S_RUN) && (per_cnt < duty_s);

    // Restart on the final cycle only counts if that cycle actually completes,
    // i.e. it is not frozen by pause.
    assign start_run = run && ((state == S_IDLE) || (final_cyc && !pause));

    // Wrapping ADDR_W-bit sum; two's complement makes signed steps work unchanged.
    always_comb begin
        step = '0;
        if (en_win)             step = step + incr_s;
        if (win_end)            step = step + shin_s;
        if (win_end && in_last) step = step + shout_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr    <= '0;
            per_cnt <= '0;
            dly_cnt <= '0;
            ic      <= '0;
            oc      <= '0;
            per_s   <= '0;
            duty_s  <= '0;
            delay_s <= '0;
            itin_s  <= '0;
            itout_s <= '0;
            incr_s  <= '0;
            shin_s  <= '0;
            shout_s <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else if (start_run) begin
            per_s   <= per_c;
            duty_s  <= duty_c;
            delay_s <= delay;
            itin_s  <= itin_c;
            itout_s <= itout_c;
            incr_s  <= incr;
            shin_s  <= shift_in;
            shout_s <= shift_out;
            addr    <= start;
            per_cnt <= '0;
            dly_cnt <= '0;
            ic      <= '0;
            oc      <= '0;
            state   <= (delay != '0) ? S_DELAY : S_RUN;
        end else begin
            case (state)
                S_IDLE: begin
                    if (init) addr <= start;
                end
                S_DELAY: begin
                    if (!pause) begin
                        if (dly_cnt == delay_s - PERIOD_W'(1)) begin
                            dly_cnt <= '0;
                            state   <= S_RUN;
                        end else begin
                            dly_cnt <= dly_cnt + PERIOD_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        addr <= addr + step;
                        if (win_end) begin
                            per_cnt <= '0;
                            if (in_last) begin
                                ic <= '0;
                                if (out_last) begin
                                    oc    <= '0;
                                    state <= S_IDLE;
                                end else begin
                                    oc <= oc + ITER_W'(1);
                                end
                            end else begin
                                ic <= ic + ITER_W'(1);
                            end
                        end else begin
                            per_cnt <= per_cnt + PERIOD_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_en = en_win & ~pause;
    assign done   = (state == S_IDLE);

endmodule

// File: tb/tb_xaddrgen2d.sv
// Self-checking bench for xaddrgen2d. The reference model expands every accepted run
// into a flat trace of (addr, enable) per busy cycle using nested loops, then walks
// it one entry per unpaused cycle.
module tb_xaddrgen2d;
    localparam int AW = 10;
    localparam int PW = 10;
    localparam int IW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b0, run = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [IW-1:0] iter_in = '0, iter_out = '0;
    logic [PW-1:0] period = '0, duty = '0, delay = '0;
    logic [AW-1:0] start = '0, incr = '0, shift_in = '0, shift_out = '0;
    logic [AW-1:0] addr;
    logic          mem_en, done;

    always #5 clk = ~clk;

    xaddrgen2d #(.ADDR_W(AW), .PERIOD_W(PW), .ITER_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .run(run), .pause(pause), .abort(abort),
        .iter_in(iter_in), .iter_out(iter_out), .period(period), .duty(duty), .delay(delay),
        .start(start), .incr(incr), .shift_in(shift_in), .shift_out(shift_out),
        .addr(addr), .mem_en(mem_en), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [AW-1:0] q_addr[$];
    bit            q_en[$];
    logic [AW-1:0] fin_addr, m_idle;
    bit            m_act;
    int            m_idx;

    // capture for literal checks
    int cap[$];
    int eq[$];
    int busy, tcount, run_t, first_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, "_len"}, 32'(cap.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size() && i < cap.size(); i++)
            chk({nm, "_addr"}, 32'(cap[i]), 32'(eq[i]));
    endtask

    // Expand the current inputs into the full busy-cycle trace.
    task automatic build();
        int P, D, NI, NO;
        logic [AW-1:0] a;
        P  = (period == 0) ? 1 : int'(period);
        D  = (int'(duty) > P) ? P : int'(duty);
        NI = (iter_in == 0) ? 1 : int'(iter_in);
        NO = (iter_out == 0) ? 1 : int'(iter_out);
        q_addr.delete();
        q_en.delete();
        for (int d = 0; d < int'(delay); d++) begin
            q_addr.push_back(start);
            q_en.push_back(1'b0);
        end
        a = start;
        for (int o = 0; o < NO; o++)
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < P; p++) begin
                    q_addr.push_back(a);
                    q_en.push_back(p < D);
                    if (p < D) a = a + incr;
                    if (p == P - 1) a = a + shift_in;
                    if (p == P - 1 && i == NI - 1) a = a + shift_out;
                end
        fin_addr = a;
        m_act = 1'b1;
        m_idx = 0;
    endtask

    // Called at posedge+1 with inputs already set; checks, advances model, waits one clock.
    task automatic tick();
        logic [AW-1:0] ea;
        bit ee, ed;
        #2;
        ea = m_act ? q_addr[m_idx] : m_idle;
        ee = m_act && q_en[m_idx] && !pause;
        ed = !m_act;
        chk("addr", 32'(addr), 32'(ea));
        chk("mem_en", 32'(mem_en), 32'(ee));
        chk("done", 32'(done), 32'(ed));
        if (mem_en === 1'b1) begin
            cap.push_back(int'(addr));
            if (first_en < 0) first_en = tcount - run_t;
        end
        if (done === 1'b0) busy++;
        if (abort) begin
            m_idle = ea;
            m_act = 1'b0;
        end else if (!m_act) begin
            if (run) build();
            else if (init) m_idle = start;
        end else if (!pause) begin
            if (m_idx == q_addr.size() - 1) begin
                if (run) build();
                else begin
                    m_act = 1'b0;
                    m_idle = fin_addr;
                end
            end else begin
                m_idx++;
            end
        end
        tcount++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg(input int st, input int inc, input int per, input int dty,
                             input int it_i, input int it_o, input int sh_i, input int sh_o,
                             input int dly);
        start = AW'(st); incr = AW'(inc); period = PW'(per); duty = PW'(dty);
        iter_in = IW'(it_i); iter_out = IW'(it_o); shift_in = AW'(sh_i); shift_out = AW'(sh_o);
        delay = PW'(dly);
        cap.delete();
        busy = 0;
        first_en = -1;
        run_t = tcount;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic finish_wait();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) chk("timeout_done", 32'(0), 32'(1));
    endtask

    initial begin
        m_act = 1'b0; m_idle = '0; m_idx = 0; fin_addr = '0;
        busy = 0; tcount = 0; run_t = 0; first_en = -1;

        // reset values
        @(posedge clk); #1;
        chk("rst_addr", 32'(addr), 32'(0));
        chk("rst_mem_en", 32'(mem_en), 32'(0));
        chk("rst_done", 32'(done), 32'(1));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic inner loop: 0,1 | 2,3 | 4,5
        start_cfg(0, 1, 4, 2, 3, 1, 0, 0, 0);
        finish_wait();
        eq.delete(); for (int k = 0; k < 6; k++) eq.push_back(k);
        chk_seq("t1");
        chk("t1_busy", 32'(busy), 32'(12));
        chk("t1_first", 32'(first_en), 32'(1));
        chk("t1_final_addr", 32'(addr), 32'(6));

        // outer loop with shift_out=8
        start_cfg(0, 1, 2, 2, 2, 3, 0, 8, 0);
        finish_wait();
        eq.delete();
        for (int o = 0; o < 3; o++) for (int k = 0; k < 4; k++) eq.push_back(12 * o + k);
        chk_seq("t2");
        chk("t2_busy", 32'(busy), 32'(12));
        chk("t2_final_addr", 32'(addr), 32'(36));

        // delay=5
        start_cfg(7, 1, 1, 1, 1, 1, 0, 0, 5);
        finish_wait();
        eq.delete(); eq.push_back(7);
        chk_seq("t3");
        chk("t3_first", 32'(first_en), 32'(6));
        chk("t3_busy", 32'(busy), 32'(6));

        // pause 3 cycles mid-window
        start_cfg(0, 1, 4, 2, 3, 1, 0, 0, 0);
        tick();
        pause = 1'b1;
        repeat (3) tick();
        pause = 1'b0;
        finish_wait();
        eq.delete(); for (int k = 0; k < 6; k++) eq.push_back(k);
        chk_seq("t4");
        chk("t4_busy", 32'(busy), 32'(15));

        // seamless restart on final cycle with start=100
        start_cfg(0, 1, 4, 2, 3, 1, 0, 0, 0);
        repeat (11) tick();
        run = 1'b1; start = AW'(100);
        tick();
        run = 1'b0;
        finish_wait();
        eq.delete();
        for (int k = 0; k < 6; k++) eq.push_back(k);
        for (int k = 0; k < 6; k++) eq.push_back(100 + k);
        chk_seq("t5");
        chk("t5_busy", 32'(busy), 32'(24));

        // abort mid-RUN
        start_cfg(0, 1, 4, 2, 3, 1, 0, 0, 0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'(1));
        chk("abort_addr", 32'(addr), 32'(2));
        tick();

        // clamps: period=0, iters=0, duty>period -> single enabled cycle
        start_cfg(50, 2, 0, 3, 0, 0, 0, 0, 0);
        finish_wait();
        eq.delete(); eq.push_back(50);
        chk_seq("clamp");
        chk("clamp_busy", 32'(busy), 32'(1));
        chk("clamp_final_addr", 32'(addr), 32'(52));

        // reset mid-RUN
        start_cfg(9, 1, 4, 2, 3, 1, 0, 0, 0);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(addr), 32'(0));
        chk("midrst_mem_en", 32'(mem_en), 32'(0));
        chk("midrst_done", 32'(done), 32'(1));
        m_act = 1'b0; m_idle = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            run       = ($urandom_range(0, 5) == 0);
            abort     = ($urandom_range(0, 49) == 0);
            pause     = ($urandom_range(0, 4) == 0);
            init      = ($urandom_range(0, 7) == 0);
            period    = PW'($urandom_range(0, 5));
            duty      = PW'($urandom_range(0, 6));
            delay     = ($urandom_range(0, 2) == 0) ? PW'($urandom_range(1, 3)) : '0;
            iter_in   = IW'($urandom_range(0, 3));
            iter_out  = IW'($urandom_range(0, 3));
            start     = AW'($urandom);
            incr      = AW'($urandom);
            shift_in  = AW'($urandom);
            shift_out = AW'($urandom);
            tick();
        end
        run = 1'b0; abort = 1'b0; pause = 1'b0; init = 1'b0;
        finish_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
